// File: rtl/decoder_3to8_stream.sv
// Streaming binary-to-one-hot decoder with valid/ready on both sides.
// A main output register plus one skid register give full throughput under backpressure.
module decoder_3to8_stream #(
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        in_code,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [(2**N)-1:0]   out_onehot,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    xfer_cnt
);

  localparam int OUT_W = 2**N;

  // Bit 0 doubles as "main register holds a word".
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [OUT_W-1:0] main_onehot_reg;
  logic [N-1:0]     skid_code_reg;
  logic             in_ready_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [OUT_W-1:0] dec_in;
  logic [OUT_W-1:0] dec_skid;

  logic accept;
  logic xfer;
  logic main_load;
  logic main_from_skid;
  logic main_clear;
  logic skid_load;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_dec
      assign dec_in[gi]   = (in_code == N'(gi));
      assign dec_skid[gi] = (skid_code_reg == N'(gi));
    end
  endgenerate

  assign accept = in_valid && in_ready_reg;
  assign xfer   = state_reg[0] && out_ready;

  always_comb begin
    state_next     = state_reg;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          main_load  = 1'b1;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          main_load = 1'b1;
        end else if (xfer) begin
          state_next = EMPTY;
          main_clear = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          skid_load  = 1'b1;
        end
      end
      FULL: begin
        if (xfer) begin
          state_next     = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
        main_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= EMPTY;
      main_onehot_reg <= '0;
      skid_code_reg   <= '0;
      in_ready_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      // in_ready comes straight from this flop so out_ready never reaches it combinationally.
      in_ready_reg <= (state_next != FULL);
      if (main_load) begin
        main_onehot_reg <= dec_in;
      end else if (main_from_skid) begin
        main_onehot_reg <= dec_skid;
      end else if (main_clear) begin
        main_onehot_reg <= '0;
      end
      if (skid_load) begin
        skid_code_reg <= in_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_clr) begin
      cnt_reg <= '0;
    end else if (accept && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = state_reg[0];
  assign out_onehot = main_onehot_reg;
  assign xfer_cnt   = cnt_reg;

endmodule

// File: tb/tb_decoder_3to8_stream.sv
// Self-checking bench: table vectors, directed corner sequences and random traffic
// compared against a depth-2 FIFO reference model.
module tb_decoder_3to8_stream;

  logic       clk;
  logic       rst_n;
  logic [2:0] in_code;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic       out_ready;
  logic       cnt_clr;
  logic [3:0] xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ordered words in flight (at most two) and the transfer count.
  int q[$];
  int model_cnt = 0;

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       ordy;
    logic [7:0] exp_onehot;
    logic       exp_valid;
    logic       exp_ready;
  } vec_t;

  vec_t tbl[6];

  decoder_3to8_stream #(.N(3), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_onehot(out_onehot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_onehot();
    if (q.size() == 0) return 8'h00;
    return 8'(2 ** q[0]);
  endfunction

  task automatic cycle(input logic v, input logic [2:0] c, input logic ordy, input logic clr);
    bit acc;
    bit xf;
    in_valid  = v;
    in_code   = c;
    out_ready = ordy;
    cnt_clr   = clr;
    acc = v && (q.size() < 2);
    xf  = ordy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (xf) void'(q.pop_front());
    if (acc) q.push_back(int'(c));
    if (clr) model_cnt = 0;
    else if (acc && model_cnt < 15) model_cnt++;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_onehot", 32'(out_onehot), 32'(model_onehot()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(model_cnt));
    $display("cyc t=%0t v=%0b code=%0d ordy=%0b clr=%0b -> onehot=%02h valid=%0b ready=%0b cnt=%0d",
             $time, v, c, ordy, clr, out_onehot, out_valid, in_ready, xfer_cnt);
  endtask

  task automatic model_reset();
    q.delete();
    model_cnt = 0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 3'd3, 1'b0, 8'h08, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 3'd6, 1'b0, 8'h08, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 3'd1, 1'b0, 8'h08, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 3'd1, 1'b1, 8'h40, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 3'd1, 1'b1, 8'h02, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1};

    // Reset held with a valid word presented.
    rst_n = 1'b0; in_valid = 1'b1; in_code = 3'd5; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_onehot", 32'(out_onehot), 32'h00);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 3'd5, 1'b1, 1'b0);
    chk("first_word", 32'(out_onehot), 32'h20);
    cycle(1'b0, 3'd0, 1'b1, 1'b1);

    // Back-to-back sweep of all codes.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 3'(i), 1'b1, 1'b0);
      chk("sweep_onehot", 32'(out_onehot), 32'(8'h01 << i));
      chk("sweep_valid", 32'(out_valid), 32'd1);
    end
    chk("sweep_cnt", 32'(xfer_cnt), 32'd8);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);

    // Backpressure table.
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, tbl[i].c, tbl[i].ordy, 1'b0);
      chk("tbl_onehot", 32'(out_onehot), 32'(tbl[i].exp_onehot));
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
      chk("tbl_ready", 32'(in_ready), 32'(tbl[i].exp_ready));
    end

    // Stall stability with a toggling source.
    cycle(1'b1, 3'd2, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 3'(i), 1'b0, 1'b0);
      chk("stall_onehot", 32'(out_onehot), 32'h04);
    end
    cycle(1'b0, 3'd0, 1'b1, 1'b0);
    chk("stall_drain1", 32'(out_onehot), 32'h80);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);
    chk("stall_drain2", 32'(out_valid), 32'd0);

    // Counter saturation and clear priority.
    cycle(1'b0, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 3'(i), 1'b1, 1'b0);
    chk("cnt_sat", 32'(xfer_cnt), 32'd15);
    cycle(1'b1, 3'd3, 1'b1, 1'b1);
    chk("cnt_clr_prio", 32'(xfer_cnt), 32'd0);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 3'($urandom), ($urandom % 3) != 0, ($urandom % 50) == 0);
    end

    // Async reset while both entries are full.
    cycle(1'b0, 3'd0, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);
    cycle(1'b1, 3'd4, 1'b0, 1'b0);
    cycle(1'b1, 3'd1, 1'b0, 1'b0);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_onehot", 32'(out_onehot), 32'h00);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 3'd0, 1'b1, 1'b0);
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    cycle(1'b1, 3'd6, 1'b1, 1'b0);
    chk("post_rst_word", 32'(out_onehot), 32'h40);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
